csa_tree_12to2: RTL and testbench
=================================

Name: csa_tree_12to2

Overview:
- Carry-save reduction tree that compresses twelve WIDTH-bit partial products into one redundant sum/carry pair, with no carry-propagate add.
- Sits ahead of the final carry-propagate adder in the floating-point multiplier/accumulator datapath.
- Ten 3:2 full-adder CSA cells are arranged in four levels, and the result is registered once at the output.

Parameters:
- WIDTH, 48, width of each partial product and of the s9_final/c9_final outputs.
- IW, 53, internal tree width. Must be at least WIDTH+4 to hold the exact sum of 12 operands without loss.

Ports:
- clk  input  1  single clock; all registers update on rising edge.
- nreset  input  1  reset, asynchronous and active-high: nreset=1 clears all registers immediately, independent of clk.
- product  input  12 x WIDTH (unpacked array [0:11])  partial products to compress.
- s9_final  output  WIDTH  registered redundant sum vector, equal to s9[WIDTH-1:0].
- c9_final  output  WIDTH  registered redundant carry vector, equal to c9[WIDTH-1:0].
- carry_out  output  1  registered bit WIDTH of (s9+c9), i.e. bit 48 of the exact 12-operand sum.

Behaviour:
- CSA cell, operands x, y, z:
  - s = x^y^z
  - c = ((x&y)|(x&z)|(y&z)) << 1
  - Operands are zero-extended to IW; no bits are dropped inside the tree.
- Internal nets s0..s9 and c0..c9 are IW-bit and use exactly these names, because verification probes them hierarchically.
- Level 1:
  - (s0,c0) = CSA(p0,p1,p2)
  - (s1,c1) = CSA(p3,p4,p5)
  - (s2,c2) = CSA(p6,p7,p8)
  - (s3,c3) = CSA(p9,p10,p11)
- Level 2:
  - (s4,c4) = CSA(s0,c0,s1)
  - (s5,c5) = CSA(c1,s2,c2)
- Level 3:
  - (s6,c6) = CSA(s4,c4,s5)
  - (s7,c7) = CSA(c5,s3,c3)
- Level 4:
  - (s8,c8) = CSA(s6,c6,s7)
  - (s9,c9) = CSA(s8,c8,c7)
- Invariant: s9+c9 (IW-bit) equals the exact sum of product[0..11] for all inputs, including all-ones inputs.
- Tree is purely combinational from product to s9/c9.
- Output register captures s9[WIDTH-1:0], c9[WIDTH-1:0] and (s9+c9)[WIDTH] on every rising clk edge.
- This carry_out adder is the only carry-propagate logic in the block.
- Latency is 1 cycle: inputs stable before edge N appear on the outputs after edge N.
- No enable or handshake; a new set of products is accepted every cycle.
- Reset: while nreset=1, s9_final=0, c9_final=0, carry_out=0. Assertion mid-operation clears the outputs asynchronously.
- On deassertion, the first rising edge with nreset=0 loads the tree result.
- Wrap: (s9_final+c9_final) mod 2^WIDTH equals (sum of products) mod 2^WIDTH. Overflow above bit WIDTH is reported only via carry_out, and bits above WIDTH are not output.

Optional Feature:
- Macro CSA_MID_PIPE_EN.
- When defined:
  - An extra register stage, reset by nreset like the output register, sits after level 2 and captures s3,c3,s4,c4,s5,c5.
  - Levels 3-4 are fed from those registers.
  - Total latency becomes 2 cycles.
  - Probed nets s6..s9 and c6..c9 reflect the previous cycle's products.
- When undefined: the tree is fully combinational and latency is 1 cycle as above.

Test Plan:
- Reset: nreset=1 with product all 0xFFFF_FFFF_FFFF, toggle clk -> s9_final=0, c9_final=0, carry_out=0. Assert nreset=1 between edges while outputs are nonzero -> outputs go to 0 before the next edge.
- All zeros: 12 x 0, nreset=0, one edge -> s9_final=0, c9_final=0, carry_out=0.
- Ones: product[i]=1 for all i -> after one edge, s9_final+c9_final=12 (0x00C) and carry_out=0.
- Max overflow: all products 0xFFFF_FFFF_FFFF -> exact sum 0xB_FFFF_FFFF_FFF4; (s9_final+c9_final) mod 2^48 = 0xFFFF_FFFF_FFF4; carry_out=1 (bit 48 of 0xB...).
- Back-to-back random: 10 consecutive cycles of 32-bit $random per product -> each cycle s9+c9 equals the 64-bit reference sum. Outputs match that cycle's products with 1-cycle latency (2 with CSA_MID_PIPE_EN), with no stale or skipped results.
- Single-hot: product[7]=0x8000_0000_0000, others 0 -> s9_final|c9_final sums to 0x8000_0000_0000, carry_out=0. Then product[0]=product[11]=0x8000_0000_0000 -> sum mod 2^48 = 0, carry_out=1.

Source files
------------

// File: rtl/csa_tree_12to2.sv
`default_nettype none
// ============================================================================
//  Module      : csa_tree_12to2
//  Description : Four-level carry-save tree reducing twelve WIDTH-bit partial
//                products to one registered sum/carry pair plus carry_out,
//                the bit WIDTH of the exact total. Defining CSA_MID_PIPE_EN
//                adds a register stage after level 2, giving 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_tree_12to2 #(
   parameter int WIDTH = 48,
   parameter int IW    = 53
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] product [0:11],
   output logic [WIDTH-1:0] s9_final,
   output logic [WIDTH-1:0] c9_final,
   output logic             carry_out
);

   // Zero-extended operands and tree nets. The nets keep these exact names
   // so that they can be probed hierarchically.
   logic [IW-1:0] p [0:11];
   logic [IW-1:0] s0, s1, s2, s3, s4, s5, s6, s7, s8, s9;
   logic [IW-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8, c9;

   // Inputs to level 3. These are either the level-2 results themselves or
   // the registered copies of them.
   logic [IW-1:0] s3_l3, c3_l3, s4_l3, c4_l3, s5_l3, c5_l3;

   // Full-width sum of the final pair. Only bit WIDTH is kept, as carry_out.
   logic [IW-1:0] tree_sum;
   logic          unused_tree_hi;

   function automatic logic [IW-1:0] csa_sum(input logic [IW-1:0] x,
                                             input logic [IW-1:0] y,
                                             input logic [IW-1:0] z);
      return x ^ y ^ z;
   endfunction

   // IW leaves enough headroom that the shift never drops a set bit.
   function automatic logic [IW-1:0] csa_carry(input logic [IW-1:0] x,
                                               input logic [IW-1:0] y,
                                               input logic [IW-1:0] z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 12; gi++) begin : g_ext
         assign p[gi] = {{(IW-WIDTH){1'b0}}, product[gi]};
      end
   endgenerate

   // Level 1
   assign s0 = csa_sum  (p[0], p[1],  p[2]);
   assign c0 = csa_carry(p[0], p[1],  p[2]);
   assign s1 = csa_sum  (p[3], p[4],  p[5]);
   assign c1 = csa_carry(p[3], p[4],  p[5]);
   assign s2 = csa_sum  (p[6], p[7],  p[8]);
   assign c2 = csa_carry(p[6], p[7],  p[8]);
   assign s3 = csa_sum  (p[9], p[10], p[11]);
   assign c3 = csa_carry(p[9], p[10], p[11]);

   // Level 2
   assign s4 = csa_sum  (s0, c0, s1);
   assign c4 = csa_carry(s0, c0, s1);
   assign s5 = csa_sum  (c1, s2, c2);
   assign c5 = csa_carry(c1, s2, c2);

`ifdef CSA_MID_PIPE_EN
   // Mid-tree pipeline stage: hold the six vectors feeding level 3
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         s3_l3 <= '0;
         c3_l3 <= '0;
         s4_l3 <= '0;
         c4_l3 <= '0;
         s5_l3 <= '0;
         c5_l3 <= '0;
      end else begin
         s3_l3 <= s3;
         c3_l3 <= c3;
         s4_l3 <= s4;
         c4_l3 <= c4;
         s5_l3 <= s5;
         c5_l3 <= c5;
      end
   end
`else
   assign s3_l3 = s3;
   assign c3_l3 = c3;
   assign s4_l3 = s4;
   assign c4_l3 = c4;
   assign s5_l3 = s5;
   assign c5_l3 = c5;
`endif

   // Level 3
   assign s6 = csa_sum  (s4_l3, c4_l3, s5_l3);
   assign c6 = csa_carry(s4_l3, c4_l3, s5_l3);
   assign s7 = csa_sum  (c5_l3, s3_l3, c3_l3);
   assign c7 = csa_carry(c5_l3, s3_l3, c3_l3);

   // Level 4
   assign s8 = csa_sum  (s6, c6, s7);
   assign c8 = csa_carry(s6, c6, s7);
   assign s9 = csa_sum  (s8, c8, c7);
   assign c9 = csa_carry(s8, c8, c7);

   // This adder is the only carry-propagate logic in the block.
   assign tree_sum       = s9 + c9;
   assign unused_tree_hi = ^tree_sum[IW-1:WIDTH+1];

   // Output register: truncated redundant pair and the overflow bit
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         s9_final  <= '0;
         c9_final  <= '0;
         carry_out <= 1'b0;
      end else begin
         s9_final  <= s9[WIDTH-1:0];
         c9_final  <= c9[WIDTH-1:0];
         carry_out <= tree_sum[WIDTH];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_csa_tree_12to2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_tree_12to2
//  Description : Scoreboard bench for csa_tree_12to2. The expected total of
//                each product set goes into a queue when the set is driven,
//                and a monitor pops that entry when the result emerges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_tree_12to2;

   localparam int WIDTH = 48;
`ifdef CSA_MID_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [WIDTH-1:0] MAXV = 48'hFFFF_FFFF_FFFF;
   localparam logic [WIDTH-1:0] MSB  = 48'h8000_0000_0000;

   typedef struct {
      logic [WIDTH-1:0] lo;
      logic             co;
      string            tag;
   } exp_t;

   logic             clk;
   logic             nreset;
   logic [WIDTH-1:0] product [0:11];
   logic [WIDTH-1:0] s9_final;
   logic [WIDTH-1:0] c9_final;
   logic             carry_out;

   logic             drv_valid;
   logic [LAT-1:0]   vld_pipe;
   exp_t             exp_q[$];
   string            cur_tag;
   int               passed;
   int               total;

   csa_tree_12to2 #(.WIDTH(WIDTH), .IW(53)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .product   (product),
      .s9_final  (s9_final),
      .c9_final  (c9_final),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, want);
   endtask

   // Reference: plain integer sum of the twelve products.
   function automatic logic [63:0] ref_sum();
      logic [63:0] acc = 64'd0;
      for (int i = 0; i < 12; i++) acc += {16'd0, product[i]};
      return acc;
   endfunction

   // Push the expected result for the current products, then hold them one cycle.
   task automatic issue(input string tag);
      logic [63:0] s;
      exp_t        e;
      s      = ref_sum();
      e.lo   = s[WIDTH-1:0];
      e.co   = s[WIDTH];
      e.tag  = tag;
      exp_q.push_back(e);
      drv_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_all(input logic [WIDTH-1:0] v);
      for (int i = 0; i < 12; i++) product[i] = v;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Track which cycles carry a scored result at the outputs.
   always @(posedge clk or posedge nreset) begin
      if (nreset) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | LAT'(drv_valid);
   end

   // Monitor: pop and compare whenever a scored result is presented.
   always @(posedge clk) begin
      exp_t        e;
      logic [WIDTH-1:0] got;
      #1;
      if (!nreset && vld_pipe[LAT-1]) begin
         if (exp_q.size() == 0) begin
            check("result_without_expectation", 64'd1, 64'd0);
         end else begin
            e   = exp_q.pop_front();
            got = s9_final + c9_final;
            check({e.tag, "_sum"},   {16'd0, got},       {16'd0, e.lo});
            check({e.tag, "_carry"}, {63'd0, carry_out}, {63'd0, e.co});
         end
      end
   end

   initial begin
      passed    = 0;
      total     = 0;
      drv_valid = 1'b0;
      nreset    = 1'b1;
      set_all(MAXV);

      // Held in reset with maximal inputs: outputs stay cleared.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_s9", {16'd0, s9_final}, 64'd0);
      check("reset_c9", {16'd0, c9_final}, 64'd0);
      check("reset_co", {63'd0, carry_out}, 64'd0);

      nreset = 1'b0;
      set_all('0);   issue("zeros");
      set_all(48'd1); issue("ones");
      set_all(MAXV); issue("max");
      set_all('0); product[7] = MSB; issue("hot7");
      set_all('0); product[0] = MSB; product[11] = MSB; issue("hot0_11");
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 12; i++) product[i] = {16'd0, $urandom()};
         issue($sformatf("rand32_%0d", r));
      end
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 12; i++) product[i] = {$urandom_range(65535, 0), $urandom()} & MAXV;
         issue($sformatf("rand48_%0d", r));
      end
      drv_valid = 1'b0;
      drain();

      // Asynchronous reset between edges while outputs are nonzero.
      set_all(MAXV);
      repeat (LAT + 1) @(posedge clk);
      #3;
      check("pre_reset_nonzero", {63'd0, (s9_final | c9_final) != '0}, 64'd1);
      nreset = 1'b1;
      #1;
      check("async_reset_s9", {16'd0, s9_final}, 64'd0);
      check("async_reset_c9", {16'd0, c9_final}, 64'd0);
      check("async_reset_co", {63'd0, carry_out}, 64'd0);

      // Recovery: first edges after release load fresh tree results.
      @(negedge clk);
      nreset = 1'b0;
      set_all(48'd1); issue("post_reset_ones");
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 12; i++) product[i] = {$urandom_range(65535, 0), $urandom()} & MAXV;
         issue($sformatf("post_rand_%0d", r));
      end
      drv_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
